// File: rtl/smg_scan_module.sv
`default_nettype none
// ============================================================================
// Module      : smg_scan_module
// Description : Six-digit multiplexed 7-segment scanner with per-frame data
//               snapshot, invalid-BCD marking and optional whole-display blink
//               (compiled only when SMG_BLINK_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module smg_scan_module #(
    parameter int T_SCAN       = 50000,
    parameter int BLINK_FRAMES = 83
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [23:0] Digit_Data,
`ifdef SMG_BLINK_EN
    input  logic        Blink,
`endif
    output logic [3:0]  Number_Data,
    output logic [5:0]  rScan,
    output logic        Frame_Done
);

    localparam int          C_CNT_W  = (T_SCAN > 1) ? $clog2(T_SCAN) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(T_SCAN - 1);
    localparam logic [2:0]  C_IDX_LAST = 3'd5;
    localparam logic [5:0]  C_BLANK    = 6'b111_111;

    logic               started_q, started_d;
    logic [C_CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]         idx_q,     idx_d;
    logic [23:0]        snap_q,    snap_d;
    logic [5:0]         scan_q,    scan_d;
    logic [3:0]         num_q,     num_d;
    logic               fd_q,      fd_d;
    logic               w_wrap;

    // Codes 10..15 collapse to 10, which the encoder shows as a lone decimal point.
    function automatic logic [3:0] f_bcd(input logic [3:0] d);
        return (d > 4'd9) ? 4'd10 : d;
    endfunction

    function automatic logic [3:0] f_pick(input logic [23:0] s, input logic [2:0] i);
        logic [3:0] r;
        case (i)
            3'd0:    r = s[3:0];
            3'd1:    r = s[7:4];
            3'd2:    r = s[11:8];
            3'd3:    r = s[15:12];
            3'd4:    r = s[19:16];
            default: r = s[23:20];
        endcase
        return r;
    endfunction

    always_comb begin
        started_d = started_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        scan_d    = scan_q;
        num_d     = num_q;
        fd_d      = 1'b0;
        w_wrap    = 1'b0;
        if (!started_q) begin
            started_d = 1'b1;
            cnt_d     = '0;
            idx_d     = 3'd0;
            scan_d    = 6'b111_110;
            snap_d    = Digit_Data;
            num_d     = f_bcd(Digit_Data[3:0]);
        end else if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == C_IDX_LAST) begin
                // Frame boundary: digit 0 bypasses the snapshot it is loading.
                idx_d  = 3'd0;
                snap_d = Digit_Data;
                num_d  = f_bcd(Digit_Data[3:0]);
                fd_d   = 1'b1;
                w_wrap = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
                num_d = f_bcd(f_pick(snap_q, idx_d));
            end
            scan_d = ~(6'b000_001 << idx_d);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            started_q <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            snap_q    <= '0;
            scan_q    <= C_BLANK;
            num_q     <= 4'd0;
            fd_q      <= 1'b0;
        end else begin
            started_q <= started_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            scan_q    <= scan_d;
            num_q     <= num_d;
            fd_q      <= fd_d;
        end
    end

    assign Number_Data = num_q;
    assign Frame_Done  = fd_q;

`ifdef SMG_BLINK_EN
    localparam int C_BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [C_BF_W-1:0] C_BF_LAST = C_BF_W'(BLINK_FRAMES - 1);

    logic [C_BF_W-1:0] bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic              blank_q, blank_d;

    // The wrap edge is the event that raises Frame_Done, so counting it here
    // aligns the phase flip with the first cycle of the new frame.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (w_wrap) begin
            if (bcnt_q == C_BF_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
        blank_d = Blink & phase_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    assign rScan = scan_q | {6{blank_q}};
`else
    assign rScan = scan_q;
`endif

endmodule
`default_nettype wire
